// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and helpers for the FIFO family (single-clock
//                and dual-clock variants).
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Read-side presentation mode
    typedef enum logic {
        FIFO_STD  = 1'b0,   // registered read, one-cycle latency
        FIFO_FWFT = 1'b1    // head word shown without a read request
    } fifo_mode_e;

    // Pointer width: address bits plus one wrap bit
    function automatic int pointer_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when depth is a power of two and at least two
    function automatic bit depth_is_valid(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/synchronous_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : synchronous_fifo_if
//  Description : Write/read handshake and status bundle for synchronous_fifo.
//                master = user of the FIFO, slave = the FIFO itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface synchronous_fifo_if
    import fifo_pkg::*;
#(
    parameter int NUM_ADDRESS = 8,
    parameter int DATA_LENGTH = 32
);
    localparam int POINTER_LENGTH = pointer_width(NUM_ADDRESS);

    logic                      w_en;
    logic [DATA_LENGTH-1:0]    write_data;
    logic                      r_en;
    logic                      clear_flags;
    logic [DATA_LENGTH-1:0]    read_data;
    logic                      read_valid;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      almost_full;
    logic                      almost_empty;
    logic [POINTER_LENGTH-1:0] fill_count;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output w_en, write_data, r_en, clear_flags,
        input  read_data, read_valid, fifo_full, fifo_empty,
               almost_full, almost_empty, fill_count, overflow, underflow
    );

    modport slave (
        input  w_en, write_data, r_en, clear_flags,
        output read_data, read_valid, fifo_full, fifo_empty,
               almost_full, almost_empty, fill_count, overflow, underflow
    );

endinterface : synchronous_fifo_if
`default_nettype wire

// File: rtl/sync_fifo_storage.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_storage
//  Description : NUM_ADDRESS x DATA_LENGTH word array, one synchronous write
//                port and one asynchronous read port. Contents are never
//                reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_storage #(
    parameter int NUM_ADDRESS    = 8,
    parameter int DATA_LENGTH    = 32,
    parameter int ADDRESS_LENGTH = 3
) (
    input  wire logic                      clk,
    input  wire logic                      write_enable,
    input  wire logic [ADDRESS_LENGTH-1:0] write_address,
    input  wire logic [DATA_LENGTH-1:0]    write_data,
    input  wire logic [ADDRESS_LENGTH-1:0] read_address,
    output logic      [DATA_LENGTH-1:0]    read_data
);

    logic [DATA_LENGTH-1:0] mem [NUM_ADDRESS];

    // Write port: store the word on an accepted write
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule : sync_fifo_storage
`default_nettype wire

// File: rtl/synchronous_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : synchronous_fifo
//  Description : Single-clock FIFO with fill count, almost-full/empty levels,
//                optional first-word-fall-through, sticky overflow/underflow
//                and a flag clear input. Binary pointers with an extra wrap
//                bit.
//  Revision    : 1.0  initial release
// ============================================================================
module synchronous_fifo
    import fifo_pkg::*;
#(
    parameter int NUM_ADDRESS  = 8,
    parameter int DATA_LENGTH  = 32,
    parameter int FWFT         = 0,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input wire logic         clk,
    input wire logic         reset,
    synchronous_fifo_if.slave bus
);

    localparam int ADDRESS_LENGTH = $clog2(NUM_ADDRESS);
    localparam int POINTER_LENGTH = pointer_width(NUM_ADDRESS);
    localparam fifo_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [POINTER_LENGTH-1:0] PTR_ONE   = POINTER_LENGTH'(1);
    localparam logic [POINTER_LENGTH-1:0] AF_LEVEL  = POINTER_LENGTH'(ALMOST_FULL);
    localparam logic [POINTER_LENGTH-1:0] AE_LEVEL  = POINTER_LENGTH'(ALMOST_EMPTY);

    // Parameter sanity, stop elaboration on a bad configuration
    if (!depth_is_valid(NUM_ADDRESS)) begin : g_bad_depth
        $fatal(1, "synchronous_fifo: NUM_ADDRESS must be a power of two >= 2");
    end
    if (DATA_LENGTH < 1) begin : g_bad_width
        $fatal(1, "synchronous_fifo: DATA_LENGTH must be >= 1");
    end
    if (ALMOST_FULL < 1 || ALMOST_FULL > NUM_ADDRESS) begin : g_bad_af
        $fatal(1, "synchronous_fifo: ALMOST_FULL out of range");
    end
    if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > NUM_ADDRESS - 1) begin : g_bad_ae
        $fatal(1, "synchronous_fifo: ALMOST_EMPTY out of range");
    end

    logic [POINTER_LENGTH-1:0] wr_ptr, rd_ptr;
    logic [POINTER_LENGTH-1:0] wr_ptr_next, rd_ptr_next;
    logic [POINTER_LENGTH-1:0] count, count_next;
    logic                      full_q, empty_q, almost_full_q, almost_empty_q;
    logic                      full_next, empty_next, almost_full_next, almost_empty_next;
    logic                      overflow_q, underflow_q;
    logic                      wr_ok, rd_ok;
    logic [DATA_LENGTH-1:0]    head_word;

    // Accept decisions and next-state pointers/status; a full FIFO still takes
    // a write when a read frees a slot in the same cycle, an empty one never
    // bypasses write data to the read side
    always_comb begin
        wr_ok       = bus.w_en & (~full_q | bus.r_en);
        rd_ok       = bus.r_en & ~empty_q;
        wr_ptr_next = wr_ok ? (wr_ptr + PTR_ONE) : wr_ptr;
        rd_ptr_next = rd_ok ? (rd_ptr + PTR_ONE) : rd_ptr;
        count_next  = wr_ptr_next - rd_ptr_next;
        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[POINTER_LENGTH-1] != rd_ptr_next[POINTER_LENGTH-1]) &&
                      (wr_ptr_next[ADDRESS_LENGTH-1:0] == rd_ptr_next[ADDRESS_LENGTH-1:0]);
        almost_full_next  = (count_next >= AF_LEVEL);
        almost_empty_next = (count_next <= AE_LEVEL);
    end

    // Pointer, count and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr         <= wr_ptr_next;
            rd_ptr         <= rd_ptr_next;
            count          <= count_next;
            full_q         <= full_next;
            empty_q        <= empty_next;
            almost_full_q  <= almost_full_next;
            almost_empty_q <= almost_empty_next;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.w_en & ~wr_ok) begin
                overflow_q <= 1'b1;
            end else if (bus.clear_flags) begin
                overflow_q <= 1'b0;
            end
            if (bus.r_en & ~rd_ok) begin
                underflow_q <= 1'b1;
            end else if (bus.clear_flags) begin
                underflow_q <= 1'b0;
            end
        end
    end

    sync_fifo_storage #(
        .NUM_ADDRESS    (NUM_ADDRESS),
        .DATA_LENGTH    (DATA_LENGTH),
        .ADDRESS_LENGTH (ADDRESS_LENGTH)
    ) storage (
        .clk           (clk),
        .write_enable  (wr_ok),
        .write_address (wr_ptr[ADDRESS_LENGTH-1:0]),
        .write_data    (bus.write_data),
        .read_address  (rd_ptr[ADDRESS_LENGTH-1:0]),
        .read_data     (head_word)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head word is shown directly; a read request pops it
        assign bus.read_data  = head_word;
        assign bus.read_valid = ~empty_q;
    end else begin : g_std
        logic [DATA_LENGTH-1:0] read_data_q;
        logic                   read_valid_q;

        // Registered read: capture the head on an accepted pop, hold otherwise
        always_ff @(posedge clk) begin
            if (reset) begin
                read_data_q  <= '0;
                read_valid_q <= 1'b0;
            end else begin
                read_valid_q <= rd_ok;
                if (rd_ok) begin
                    read_data_q <= head_word;
                end
            end
        end

        assign bus.read_data  = read_data_q;
        assign bus.read_valid = read_valid_q;
    end

    assign bus.fifo_full    = full_q;
    assign bus.fifo_empty   = empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.fill_count   = count;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule : synchronous_fifo
`default_nettype wire

// File: tb/tb_synchronous_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_synchronous_fifo
//  Description : Directed self-checking bench for synchronous_fifo, one
//                instance in standard mode and one in fall-through mode.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_synchronous_fifo;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    synchronous_fifo_if #(.NUM_ADDRESS(8), .DATA_LENGTH(32)) a_if ();
    synchronous_fifo_if #(.NUM_ADDRESS(8), .DATA_LENGTH(32)) b_if ();

    synchronous_fifo #(
        .NUM_ADDRESS(8), .DATA_LENGTH(32), .FWFT(0), .ALMOST_FULL(6), .ALMOST_EMPTY(2)
    ) dut_std (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    synchronous_fifo #(
        .NUM_ADDRESS(8), .DATA_LENGTH(32), .FWFT(1), .ALMOST_FULL(6), .ALMOST_EMPTY(2)
    ) dut_fwft (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the run stalls
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        a_if.w_en = 1'b0; a_if.r_en = 1'b0; a_if.clear_flags = 1'b0; a_if.write_data = '0;
        b_if.w_en = 1'b0; b_if.r_en = 1'b0; b_if.clear_flags = 1'b0; b_if.write_data = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state
        check("rst_empty",        32'(a_if.fifo_empty),   32'd1);
        check("rst_almost_empty", 32'(a_if.almost_empty), 32'd1);
        check("rst_full",         32'(a_if.fifo_full),    32'd0);
        check("rst_almost_full",  32'(a_if.almost_full),  32'd0);
        check("rst_count",        32'(a_if.fill_count),   32'd0);
        check("rst_overflow",     32'(a_if.overflow),     32'd0);
        check("rst_underflow",    32'(a_if.underflow),    32'd0);
        check("rst_read_valid",   32'(a_if.read_valid),   32'd0);
        check("rst_read_data",    a_if.read_data,         32'd0);
        check("rst_fwft_valid",   32'(b_if.read_valid),   32'd0);

        // 2: fill to full, thresholds, overflow
        for (int i = 0; i < 8; i++) begin
            a_if.w_en = 1'b1;
            a_if.write_data = 32'hA0 + 32'(i);
            tick();
            check("fill_count",        32'(a_if.fill_count),   32'(i + 1));
            check("fill_almost_full",  32'(a_if.almost_full),  32'((i + 1) >= 6));
            check("fill_almost_empty", 32'(a_if.almost_empty), 32'((i + 1) <= 2));
            check("fill_full",         32'(a_if.fifo_full),    32'((i + 1) == 8));
        end
        a_if.write_data = 32'hEE;
        tick();
        a_if.w_en = 1'b0;
        check("ovf_flag",  32'(a_if.overflow),   32'd1);
        check("ovf_count", 32'(a_if.fill_count), 32'd8);

        // 3: drain in order, underflow, clear
        for (int i = 0; i < 8; i++) begin
            a_if.r_en = 1'b1;
            tick();
            check("drain_data",  a_if.read_data,         32'hA0 + 32'(i));
            check("drain_valid", 32'(a_if.read_valid),   32'd1);
            check("drain_count", 32'(a_if.fill_count),   32'(7 - i));
        end
        a_if.r_en = 1'b0;
        tick();
        check("idle_valid", 32'(a_if.read_valid), 32'd0);
        check("idle_hold",  a_if.read_data,       32'hA7);
        check("idle_empty", 32'(a_if.fifo_empty), 32'd1);
        a_if.r_en = 1'b1;
        tick();
        a_if.r_en = 1'b0;
        check("udf_flag",  32'(a_if.underflow),  32'd1);
        check("udf_valid", 32'(a_if.read_valid), 32'd0);
        a_if.clear_flags = 1'b1;
        tick();
        check("clr_overflow",  32'(a_if.overflow),  32'd0);
        check("clr_underflow", 32'(a_if.underflow), 32'd0);
        a_if.r_en = 1'b1;
        tick();
        a_if.r_en = 1'b0;
        check("clr_vs_err", 32'(a_if.underflow), 32'd1);
        tick();
        a_if.clear_flags = 1'b0;
        check("clr_again", 32'(a_if.underflow), 32'd0);

        // 4: full with simultaneous write and read
        for (int i = 0; i < 8; i++) begin
            a_if.w_en = 1'b1;
            a_if.write_data = 32'hB0 + 32'(i);
            tick();
        end
        a_if.r_en = 1'b1;
        a_if.write_data = 32'hC8;
        tick();
        a_if.w_en = 1'b0;
        check("fullrw_count", 32'(a_if.fill_count), 32'd8);
        check("fullrw_full",  32'(a_if.fifo_full),  32'd1);
        check("fullrw_data",  a_if.read_data,       32'hB0);
        check("fullrw_ovf",   32'(a_if.overflow),   32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("fullrw_old", a_if.read_data, 32'hB0 + 32'(i));
        end
        tick();
        a_if.r_en = 1'b0;
        check("fullrw_new",   a_if.read_data,        32'hC8);
        check("fullrw_empty", 32'(a_if.fifo_empty),  32'd1);

        // 5: empty with simultaneous write and read, then wrap
        a_if.w_en = 1'b1;
        a_if.r_en = 1'b1;
        a_if.write_data = 32'hD0;
        tick();
        a_if.w_en = 1'b0;
        a_if.r_en = 1'b0;
        check("emptyrw_count", 32'(a_if.fill_count), 32'd1);
        check("emptyrw_udf",   32'(a_if.underflow),  32'd1);
        check("emptyrw_valid", 32'(a_if.read_valid), 32'd0);
        a_if.clear_flags = 1'b1;
        tick();
        a_if.clear_flags = 1'b0;
        a_if.r_en = 1'b1;
        tick();
        a_if.r_en = 1'b0;
        check("emptyrw_data", a_if.read_data, 32'hD0);
        for (int i = 0; i < 20; i++) begin
            a_if.w_en = 1'b1;
            a_if.write_data = 32'hE0 + 32'(i);
            tick();
            a_if.w_en = 1'b0;
            a_if.r_en = 1'b1;
            tick();
            a_if.r_en = 1'b0;
            check("wrap_data", a_if.read_data, 32'hE0 + 32'(i));
        end
        check("wrap_count", 32'(a_if.fill_count), 32'd0);
        check("wrap_udf",   32'(a_if.underflow),  32'd0);

        // 6: fall-through mode
        b_if.w_en = 1'b1;
        b_if.write_data = 32'h55;
        tick();
        b_if.w_en = 1'b0;
        check("fwft_valid", 32'(b_if.read_valid), 32'd1);
        check("fwft_data",  b_if.read_data,       32'h55);
        check("fwft_count", 32'(b_if.fill_count), 32'd1);
        b_if.r_en = 1'b1;
        tick();
        b_if.r_en = 1'b0;
        check("fwft_pop_empty", 32'(b_if.fifo_empty), 32'd1);
        check("fwft_pop_valid", 32'(b_if.read_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            b_if.w_en = 1'b1;
            b_if.write_data = 32'h60 + 32'(i);
            tick();
        end
        b_if.w_en = 1'b0;
        check("fwft5_count", 32'(b_if.fill_count),   32'd5);
        check("fwft5_head",  b_if.read_data,         32'h60);
        check("fwft5_ae",    32'(b_if.almost_empty), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_empty", 32'(b_if.fifo_empty), 32'd1);
        check("midrst_count", 32'(b_if.fill_count), 32'd0);
        check("midrst_valid", 32'(b_if.read_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_synchronous_fifo
`default_nettype wire
